// File: rtl/timer_update_sched.sv
// Command sequencer for one advanced-timer instance: orders rst/update/start/stop pulses
// and holds count-end/compare values back until the timer's next count-end for synchronous updates.
module timer_update_sched #(
    parameter int NUM_BITS = 16,
    parameter int TO_W     = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [NUM_BITS-1:0] req_cnt_end_i,
    input  logic [NUM_BITS-1:0] req_comp_ch0_i,
    input  logic [NUM_BITS-1:0] req_comp_ch1_i,
    input  logic [NUM_BITS-1:0] req_comp_ch2_i,
    input  logic [NUM_BITS-1:0] req_comp_ch3_i,
    input  logic                req_abort_i,
    input  logic [TO_W-1:0]     cfg_timeout_i,
    input  logic                cnt_end_i,
    output logic                cfg_rst_o,
    output logic                cfg_update_o,
    output logic                cfg_start_o,
    output logic                cfg_stop_o,
    output logic [NUM_BITS-1:0] cfg_cnt_end_o,
    output logic [NUM_BITS-1:0] cfg_comp_ch0_o,
    output logic [NUM_BITS-1:0] cfg_comp_ch1_o,
    output logic [NUM_BITS-1:0] cfg_comp_ch2_o,
    output logic [NUM_BITS-1:0] cfg_comp_ch3_o,
    output logic                running_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o
);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_SYNC  = 2'd2;
    localparam logic [1:0] OP_IMM   = 2'd3;

    localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_RST   = 3'd1,
        ST_UPD   = 3'd2,
        ST_GO    = 3'd3,
        WAIT_END = 3'd4,
        APPLY    = 3'd5
    } state_t;

    state_t state_r, next_state_s;

    logic                req_ready_r, busy_r, running_r;
    logic                rst_p_r, upd_p_r, start_p_r, stop_p_r, done_p_r, to_p_r;
    logic                rst_p_s, upd_p_s, start_p_s, stop_p_s, done_p_s, to_p_s;
    logic                running_next_s, load_req_s, load_sh_s, to_clr_s;
    logic                accept_s, to_hit_s;
    logic [TO_W-1:0]     to_cnt_r;

    logic [NUM_BITS-1:0] sh_cnt_end_r, sh_comp0_r, sh_comp1_r, sh_comp2_r, sh_comp3_r;
    logic [NUM_BITS-1:0] cfg_cnt_end_r, cfg_comp0_r, cfg_comp1_r, cfg_comp2_r, cfg_comp3_r;

    assign accept_s = req_valid_i && req_ready_r;
    // Timeout fires in the last WAIT_END cycle of the programmed window; zero disables it.
    assign to_hit_s = (cfg_timeout_i != {TO_W{1'b0}}) && (to_cnt_r == (cfg_timeout_i - TO_ONE));

    // Next-state and next-cycle pulse decode; every output is the registered image of these.
    always_comb begin
        next_state_s   = state_r;
        rst_p_s        = 1'b0;
        upd_p_s        = 1'b0;
        start_p_s      = 1'b0;
        stop_p_s       = 1'b0;
        done_p_s       = 1'b0;
        to_p_s         = 1'b0;
        running_next_s = running_r;
        load_req_s     = 1'b0;
        load_sh_s      = 1'b0;
        to_clr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (req_op_i)
                        OP_START: begin
                            next_state_s = ST_RST;
                            rst_p_s      = 1'b1;
                            load_req_s   = 1'b1;
                        end
                        OP_STOP: begin
                            next_state_s   = IDLE;
                            stop_p_s       = 1'b1;
                            done_p_s       = 1'b1;
                            running_next_s = 1'b0;
                        end
                        OP_SYNC: begin
                            if (running_r) begin
                                next_state_s = WAIT_END;
                                to_clr_s     = 1'b1;
                            end else begin
                                next_state_s = IDLE;
                                upd_p_s      = 1'b1;
                                done_p_s     = 1'b1;
                                load_req_s   = 1'b1;
                            end
                        end
                        OP_IMM: begin
                            next_state_s = IDLE;
                            upd_p_s      = 1'b1;
                            done_p_s     = 1'b1;
                            load_req_s   = 1'b1;
                        end
                        default: begin
                            next_state_s = IDLE;
                        end
                    endcase
                end else begin
                    next_state_s = IDLE;
                end
            end
            ST_RST: begin
                next_state_s = ST_UPD;
                upd_p_s      = 1'b1;
            end
            ST_UPD: begin
                next_state_s   = ST_GO;
                start_p_s      = 1'b1;
                done_p_s       = 1'b1;
                running_next_s = 1'b1;
            end
            ST_GO: begin
                next_state_s = IDLE;
            end
            WAIT_END: begin
                if (req_abort_i) begin
                    next_state_s = IDLE;
                    done_p_s     = 1'b1;
                end else if (cnt_end_i) begin
                    next_state_s = APPLY;
                    upd_p_s      = 1'b1;
                    done_p_s     = 1'b1;
                    load_sh_s    = 1'b1;
                end else if (to_hit_s) begin
                    next_state_s = APPLY;
                    upd_p_s      = 1'b1;
                    done_p_s     = 1'b1;
                    to_p_s       = 1'b1;
                    load_sh_s    = 1'b1;
                end else begin
                    next_state_s = WAIT_END;
                end
            end
            APPLY: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register plus registered status and pulse outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            running_r   <= 1'b0;
            rst_p_r     <= 1'b0;
            upd_p_r     <= 1'b0;
            start_p_r   <= 1'b0;
            stop_p_r    <= 1'b0;
            done_p_r    <= 1'b0;
            to_p_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            req_ready_r <= (next_state_s == IDLE);
            busy_r      <= (next_state_s != IDLE);
            running_r   <= running_next_s;
            rst_p_r     <= rst_p_s;
            upd_p_r     <= upd_p_s;
            start_p_r   <= start_p_s;
            stop_p_r    <= stop_p_s;
            done_p_r    <= done_p_s;
            to_p_r      <= to_p_s;
        end
    end

    // Saturating WAIT_END cycle counter, cleared when a synchronous update starts waiting.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (to_clr_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == WAIT_END) && (to_cnt_r != TO_MAX)) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Shadow copy of the request payload, captured on every accept.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_cnt_end_r <= {NUM_BITS{1'b0}};
            sh_comp0_r   <= {NUM_BITS{1'b0}};
            sh_comp1_r   <= {NUM_BITS{1'b0}};
            sh_comp2_r   <= {NUM_BITS{1'b0}};
            sh_comp3_r   <= {NUM_BITS{1'b0}};
        end else if (accept_s) begin
            sh_cnt_end_r <= req_cnt_end_i;
            sh_comp0_r   <= req_comp_ch0_i;
            sh_comp1_r   <= req_comp_ch1_i;
            sh_comp2_r   <= req_comp_ch2_i;
            sh_comp3_r   <= req_comp_ch3_i;
        end else begin
            sh_cnt_end_r <= sh_cnt_end_r;
            sh_comp0_r   <= sh_comp0_r;
            sh_comp1_r   <= sh_comp1_r;
            sh_comp2_r   <= sh_comp2_r;
            sh_comp3_r   <= sh_comp3_r;
        end
    end

    // Applied timer configuration: immediate loads take the request, deferred loads take the shadow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_cnt_end_r <= {NUM_BITS{1'b0}};
            cfg_comp0_r   <= {NUM_BITS{1'b0}};
            cfg_comp1_r   <= {NUM_BITS{1'b0}};
            cfg_comp2_r   <= {NUM_BITS{1'b0}};
            cfg_comp3_r   <= {NUM_BITS{1'b0}};
        end else if (load_req_s) begin
            cfg_cnt_end_r <= req_cnt_end_i;
            cfg_comp0_r   <= req_comp_ch0_i;
            cfg_comp1_r   <= req_comp_ch1_i;
            cfg_comp2_r   <= req_comp_ch2_i;
            cfg_comp3_r   <= req_comp_ch3_i;
        end else if (load_sh_s) begin
            cfg_cnt_end_r <= sh_cnt_end_r;
            cfg_comp0_r   <= sh_comp0_r;
            cfg_comp1_r   <= sh_comp1_r;
            cfg_comp2_r   <= sh_comp2_r;
            cfg_comp3_r   <= sh_comp3_r;
        end else begin
            cfg_cnt_end_r <= cfg_cnt_end_r;
            cfg_comp0_r   <= cfg_comp0_r;
            cfg_comp1_r   <= cfg_comp1_r;
            cfg_comp2_r   <= cfg_comp2_r;
            cfg_comp3_r   <= cfg_comp3_r;
        end
    end

    assign req_ready_o    = req_ready_r;
    assign busy_o         = busy_r;
    assign running_o      = running_r;
    assign cfg_rst_o      = rst_p_r;
    assign cfg_update_o   = upd_p_r;
    assign cfg_start_o    = start_p_r;
    assign cfg_stop_o     = stop_p_r;
    assign done_o         = done_p_r;
    assign timeout_o      = to_p_r;
    assign cfg_cnt_end_o  = cfg_cnt_end_r;
    assign cfg_comp_ch0_o = cfg_comp0_r;
    assign cfg_comp_ch1_o = cfg_comp1_r;
    assign cfg_comp_ch2_o = cfg_comp2_r;
    assign cfg_comp_ch3_o = cfg_comp3_r;

endmodule

// File: tb/tb_timer_update_sched.sv
// Directed bench for timer_update_sched: hand-computed pulse timing and cfg values per cycle.
module tb_timer_update_sched;

    localparam int NB = 16;
    localparam int TW = 16;

    // pulse vector order: {rst, update, start, stop, done, timeout}
    localparam logic [5:0] P_NONE  = 6'b000000;
    localparam logic [5:0] P_RST   = 6'b100000;
    localparam logic [5:0] P_UPD   = 6'b010000;
    localparam logic [5:0] P_START = 6'b001000;
    localparam logic [5:0] P_STOP  = 6'b000100;
    localparam logic [5:0] P_DONE  = 6'b000010;
    localparam logic [5:0] P_TO    = 6'b000001;

    logic          clk_s = 1'b0;
    logic          rstn_s;
    logic          req_valid_s, req_ready_s, req_abort_s, cnt_end_s;
    logic [1:0]    req_op_s;
    logic [NB-1:0] req_cnt_end_s, req_c0_s, req_c1_s, req_c2_s, req_c3_s;
    logic [TW-1:0] cfg_timeout_s;
    logic          cfg_rst_s, cfg_update_s, cfg_start_s, cfg_stop_s;
    logic [NB-1:0] cfg_cnt_end_s, cfg_c0_s, cfg_c1_s, cfg_c2_s, cfg_c3_s;
    logic          running_s, busy_s, done_s, timeout_s;
    logic [5:0]    pulses_s;

    int n_vec = 0;
    int n_err = 0;

    assign pulses_s = {cfg_rst_s, cfg_update_s, cfg_start_s, cfg_stop_s, done_s, timeout_s};

    always #5 clk_s = ~clk_s;

    timer_update_sched #(.NUM_BITS(NB), .TO_W(TW)) dut (
        .clk_i(clk_s), .rstn_i(rstn_s),
        .req_valid_i(req_valid_s), .req_ready_o(req_ready_s), .req_op_i(req_op_s),
        .req_cnt_end_i(req_cnt_end_s),
        .req_comp_ch0_i(req_c0_s), .req_comp_ch1_i(req_c1_s),
        .req_comp_ch2_i(req_c2_s), .req_comp_ch3_i(req_c3_s),
        .req_abort_i(req_abort_s), .cfg_timeout_i(cfg_timeout_s), .cnt_end_i(cnt_end_s),
        .cfg_rst_o(cfg_rst_s), .cfg_update_o(cfg_update_s),
        .cfg_start_o(cfg_start_s), .cfg_stop_o(cfg_stop_s),
        .cfg_cnt_end_o(cfg_cnt_end_s),
        .cfg_comp_ch0_o(cfg_c0_s), .cfg_comp_ch1_o(cfg_c1_s),
        .cfg_comp_ch2_o(cfg_c2_s), .cfg_comp_ch3_o(cfg_c3_s),
        .running_o(running_s), .busy_o(busy_s), .done_o(done_s), .timeout_o(timeout_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [NB-1:0] ce, input logic [NB-1:0] c0,
                        input logic [NB-1:0] c1, input logic [NB-1:0] c2, input logic [NB-1:0] c3);
        req_valid_s = 1'b1; req_op_s = op; req_cnt_end_s = ce;
        req_c0_s = c0; req_c1_s = c1; req_c2_s = c2; req_c3_s = c3;
        tick();
        req_valid_s = 1'b0;
    endtask

    initial begin
        rstn_s = 1'b0; req_valid_s = 1'b0; req_op_s = 2'd0; req_abort_s = 1'b0; cnt_end_s = 1'b0;
        req_cnt_end_s = 16'd0; req_c0_s = 16'd0; req_c1_s = 16'd0; req_c2_s = 16'd0; req_c3_s = 16'd0;
        cfg_timeout_s = 16'd0;
        #12;
        chk("rst_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
        chk("rst_ready", {31'd0, req_ready_s}, 32'd0);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_running", {31'd0, running_s}, 32'd0);
        chk("rst_cnt_end", {16'd0, cfg_cnt_end_s}, 32'd0);
        chk("rst_comp0", {16'd0, cfg_c0_s}, 32'd0);
        @(negedge clk_s);
        rstn_s = 1'b1;
        tick();
        chk("idle_ready", {31'd0, req_ready_s}, 32'd1);

        // START: rst at A, update at A+1, start+done at A+2, ready at A+3
        send(2'd0, 16'd100, 16'd25, 16'd1, 16'd2, 16'd3);
        chk("start_A_pulses", {26'd0, pulses_s}, {26'd0, P_RST});
        chk("start_A_cnt_end", {16'd0, cfg_cnt_end_s}, 32'd100);
        chk("start_A_comp0", {16'd0, cfg_c0_s}, 32'd25);
        chk("start_A_comp3", {16'd0, cfg_c3_s}, 32'd3);
        chk("start_A_busy", {31'd0, busy_s}, 32'd1);
        chk("start_A_ready", {31'd0, req_ready_s}, 32'd0);
        tick();
        chk("start_A1_pulses", {26'd0, pulses_s}, {26'd0, P_UPD});
        tick();
        chk("start_A2_pulses", {26'd0, pulses_s}, {26'd0, P_START | P_DONE});
        chk("start_A2_running", {31'd0, running_s}, 32'd1);
        tick();
        chk("start_A3_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
        chk("start_A3_ready", {31'd0, req_ready_s}, 32'd1);
        chk("start_A3_busy", {31'd0, busy_s}, 32'd0);

        // SYNC_UPD while running, cnt_end sampled on the 7th edge after accept
        send(2'd2, 16'd100, 16'd50, 16'd1, 16'd2, 16'd3);
        for (int k = 0; k < 6; k++) begin
            chk("sync_wait_comp0", {16'd0, cfg_c0_s}, 32'd25);
            chk("sync_wait_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
            tick();
        end
        chk("sync_pre_comp0", {16'd0, cfg_c0_s}, 32'd25);
        chk("sync_pre_busy", {31'd0, busy_s}, 32'd1);
        cnt_end_s = 1'b1;
        tick();
        cnt_end_s = 1'b0;
        chk("sync_apply_comp0", {16'd0, cfg_c0_s}, 32'd50);
        chk("sync_apply_pulses", {26'd0, pulses_s}, {26'd0, P_UPD | P_DONE});
        tick();
        chk("sync_post_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
        chk("sync_post_ready", {31'd0, req_ready_s}, 32'd1);

        // SYNC_UPD with timeout 5: applies after five WAIT_END cycles
        cfg_timeout_s = 16'd5;
        send(2'd2, 16'd100, 16'd60, 16'd1, 16'd2, 16'd3);
        for (int k = 0; k < 5; k++) begin
            chk("to_wait_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
            chk("to_wait_comp0", {16'd0, cfg_c0_s}, 32'd50);
            tick();
        end
        chk("to_apply_pulses", {26'd0, pulses_s}, {26'd0, P_UPD | P_DONE | P_TO});
        chk("to_apply_comp0", {16'd0, cfg_c0_s}, 32'd60);
        tick();

        // timeout 0 waits indefinitely; abort wins over a simultaneous cnt_end
        cfg_timeout_s = 16'd0;
        send(2'd2, 16'd200, 16'd70, 16'd1, 16'd2, 16'd3);
        for (int k = 0; k < 20; k++) begin
            chk("abort_wait_busy", {31'd0, busy_s}, 32'd1);
            chk("abort_wait_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
            tick();
        end
        req_abort_s = 1'b1; cnt_end_s = 1'b1;
        tick();
        req_abort_s = 1'b0; cnt_end_s = 1'b0;
        chk("abort_pulses", {26'd0, pulses_s}, {26'd0, P_DONE});
        chk("abort_comp0", {16'd0, cfg_c0_s}, 32'd60);
        chk("abort_cnt_end", {16'd0, cfg_cnt_end_s}, 32'd100);
        chk("abort_ready", {31'd0, req_ready_s}, 32'd1);
        tick();

        // STOP, then SYNC_UPD behaves as an immediate update
        send(2'd1, 16'd999, 16'd999, 16'd999, 16'd999, 16'd999);
        chk("stop_pulses", {26'd0, pulses_s}, {26'd0, P_STOP | P_DONE});
        chk("stop_running", {31'd0, running_s}, 32'd0);
        chk("stop_cnt_end", {16'd0, cfg_cnt_end_s}, 32'd100);
        tick();
        send(2'd2, 16'd100, 16'd60, 16'd10, 16'd2, 16'd3);
        chk("sync_idle_pulses", {26'd0, pulses_s}, {26'd0, P_UPD | P_DONE});
        chk("sync_idle_comp1", {16'd0, cfg_c1_s}, 32'd10);
        chk("sync_idle_running", {31'd0, running_s}, 32'd0);
        tick();
        cnt_end_s = 1'b1;
        send(2'd3, 16'd300, 16'd61, 16'd11, 16'd33, 16'd44);
        cnt_end_s = 1'b0;
        chk("imm_pulses", {26'd0, pulses_s}, {26'd0, P_UPD | P_DONE});
        chk("imm_comp2", {16'd0, cfg_c2_s}, 32'd33);
        chk("imm_cnt_end", {16'd0, cfg_cnt_end_s}, 32'd300);
        tick();

        // async reset while in ST_UPD: outputs clear at once, no start afterwards
        send(2'd0, 16'd500, 16'd5, 16'd6, 16'd7, 16'd8);
        tick();
        chk("rst_mid_upd", {26'd0, pulses_s}, {26'd0, P_UPD});
        #2;
        rstn_s = 1'b0;
        #1;
        chk("rst_mid_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
        chk("rst_mid_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_mid_cnt_end", {16'd0, cfg_cnt_end_s}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready_s}, 32'd0);
        @(negedge clk_s);
        rstn_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_after_pulses", {26'd0, pulses_s}, {26'd0, P_NONE});
        end
        chk("rst_after_ready", {31'd0, req_ready_s}, 32'd1);
        chk("rst_after_running", {31'd0, running_s}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
